// File: rtl/arb_req_queue.sv
// arb_req_queue
//   Requester-side companion to a round-robin arbiter. Each client pushes
//   transfers into its own small FIFO. A client with a non-empty FIFO raises
//   its bit of req. The arbiter answers with a one-hot gnt in the same cycle.
//   The granted client's head entry then moves into a registered output stage
//   that uses a valid/ready handshake.
//
//   While the output stage is stalled, req is forced to zero. The arbiter
//   therefore sees no requests and keeps its round-robin pointer where it is.
//
//   A grant is illegal if it is multi-hot or if it targets a client that is
//   not requesting. An illegal grant is ignored: nothing is popped and the
//   output stage is not updated. It also sets the sticky err_gnt flag, which
//   only a reset clears.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset_n    asynchronous, active-low reset
//   in_valid   per-client write valid
//   in_ready   per-client write ready (that client's FIFO is not full)
//   in_data    client i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req        request vector to the arbiter
//   gnt        grant vector from the arbiter, in the same cycle as req
//   out_valid  output stage holds a transfer
//   out_ready  downstream accepts the transfer
//   out_data   payload of the granted transfer
//   out_id     index of the client that sourced out_data
//   err_gnt    sticky flag: an illegal gnt was observed
module arb_req_queue #(
  parameter  int REQ_WIDTH  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  localparam int ID_W       = $clog2(REQ_WIDTH),
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [REQ_WIDTH-1:0]            in_valid,
  output logic [REQ_WIDTH-1:0]            in_ready,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [REQ_WIDTH-1:0]            req,
  input  logic [REQ_WIDTH-1:0]            gnt,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                 out_id,
  output logic                            err_gnt
);

  logic [DATA_WIDTH-1:0] mem    [REQ_WIDTH][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [REQ_WIDTH];
  logic [PTR_W-1:0]      rd_ptr [REQ_WIDTH];
  logic [CNT_W-1:0]      count  [REQ_WIDTH];

  logic [REQ_WIDTH-1:0]  empty;
  logic [REQ_WIDTH-1:0]  full;
  logic [REQ_WIDTH-1:0]  push;
  logic [REQ_WIDTH-1:0]  pop;
  logic                  accept_ok;
  logic                  gnt_onehot;
  logic                  gnt_in_req;
  logic                  transfer;
  logic                  gnt_illegal;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] head_data;

  // Empty/full flags come straight from the occupancy counters. As a result,
  // in_ready depends only on registered state and never on gnt or out_ready.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == CNT_W'(DEPTH));
    end
  end

  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;

  // The output stage can take a new transfer when it is empty or when its
  // current transfer is leaving this cycle. Otherwise req is withheld so that
  // the arbiter holds its round-robin state.
  assign accept_ok = !out_valid || out_ready;
  assign req       = ~empty & {REQ_WIDTH{accept_ok}};

  // A grant is honoured only if it is exactly one-hot and it lands on a
  // requesting client. Any other non-zero grant is flagged and ignored.
  // An all-zero grant means "no transfer" and is not an error.
  assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - REQ_WIDTH'(1))) == '0);
  assign gnt_in_req  = ((gnt & ~req) == '0);
  assign transfer    = gnt_onehot && gnt_in_req;
  assign gnt_illegal = (gnt != '0) && !transfer;
  assign pop         = transfer ? gnt : '0;

  // Encode the grant into a client index and select that client's head
  // entry. The result is only consumed when the grant is one-hot.
  always_comb begin
    gnt_idx   = '0;
    head_data = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (gnt[i]) begin
        gnt_idx   = ID_W'(i);
        head_data = mem[i][rd_ptr[i]];
      end
    end
  end

  // Per-client pointers and occupancy counters. DEPTH is a power of two, so
  // the pointers wrap naturally. A pop can only hit an existing head because
  // req, and hence a legal grant, requires a non-empty FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // FIFO storage has no reset. Its contents are only visible through valid
  // pointers, and a reset clears those pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output stage. A legal grant loads a new transfer. When there is no new
  // transfer, a completed handshake empties the stage. Otherwise the stage
  // holds, which keeps out_data and out_id stable during a stall.
  // err_gnt latches any illegal grant until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      err_gnt   <= 1'b0;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_id    <= gnt_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (gnt_illegal) begin
        err_gnt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue
//   Directed bench for arb_req_queue with REQ_WIDTH=4, DATA_WIDTH=32 and
//   DEPTH=2. A behavioural model keeps one queue per client plus an abstract
//   output slot. A compare process checks every DUT output against that model
//   on each falling edge. The directed sections also check hand-computed
//   literals at key points.
//
//   gnt normally comes from a directed value. While arb_en is set, a small
//   round-robin arbiter inside the bench drives gnt from the DUT's req.
module tb_arb_req_queue;

  localparam int REQ_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2;

  logic                            clk = 1'b0;
  logic                            reset_n = 1'b0;
  logic [REQ_WIDTH-1:0]            in_valid = '0;
  logic [REQ_WIDTH-1:0]            in_ready;
  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data = '0;
  logic [REQ_WIDTH-1:0]            req;
  logic [REQ_WIDTH-1:0]            gnt;
  logic                            out_valid;
  logic                            out_ready = 1'b1;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [1:0]                      out_id;
  logic                            err_gnt;

  logic [REQ_WIDTH-1:0]            gnt_drv = '0;
  logic                            arb_en = 1'b0;
  int                              rr_ptr;

  int n_vec = 0;
  int n_err = 0;

  arb_req_queue #(
    .REQ_WIDTH (REQ_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req      (req),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .err_gnt  (err_gnt)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter: grant the first requester after the last served one.
  always_comb begin
    gnt = gnt_drv;
    if (arb_en) begin
      gnt = '0;
      for (int k = 1; k <= REQ_WIDTH; k++) begin
        if (gnt == '0 && req[(rr_ptr + k) % REQ_WIDTH]) begin
          gnt[(rr_ptr + k) % REQ_WIDTH] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= REQ_WIDTH - 1;
    end else if (arb_en) begin
      for (int k = 0; k < REQ_WIDTH; k++) begin
        if (gnt[k] && req[k]) rr_ptr <= k;
      end
    end
  end

  // Behavioural model: one queue per client plus one output slot.
  logic [DATA_WIDTH-1:0] mq [REQ_WIDTH][$];
  bit                    m_ov;
  bit [DATA_WIDTH-1:0]   m_od;
  int                    m_oid;
  bit                    m_err;

  always @(posedge clk or negedge reset_n) begin : model
    int  sizes [REQ_WIDTH];
    bit  acc;
    bit  legal;
    int  k;
    if (!reset_n) begin
      for (int i = 0; i < REQ_WIDTH; i++) mq[i].delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_oid = 0;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) sizes[i] = mq[i].size();
      acc   = !m_ov || out_ready;
      legal = 1'b0;
      k     = 0;
      if ($countones(gnt) == 1) begin
        for (int i = 0; i < REQ_WIDTH; i++) begin
          if (gnt[i]) k = i;
        end
        legal = (sizes[k] > 0) && acc;
      end
      if (gnt != '0 && !legal) m_err = 1'b1;
      if (legal) begin
        m_od  = mq[k].pop_front();
        m_oid = k;
        m_ov  = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (in_valid[i] && sizes[i] < DEPTH) begin
          mq[i].push_back(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [REQ_WIDTH-1:0] req_e;
    logic [REQ_WIDTH-1:0] rdy_e;
    if (reset_n) begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        req_e[i] = (mq[i].size() != 0) && (!m_ov || out_ready);
        rdy_e[i] = (mq[i].size() < DEPTH);
      end
      check("req", 64'(req), 64'(req_e));
      check("in_ready", 64'(in_ready), 64'(rdy_e));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      check("err_gnt", 64'(err_gnt), 64'(m_err));
      if (m_ov) begin
        check("out_data", 64'(out_data), 64'(m_od));
        check("out_id", 64'(out_id), 64'(m_oid));
      end
    end
  end

  // Advance one clock and return 2 time units after the edge, with the
  // one-shot inputs cleared.
  task automatic cycle();
    @(posedge clk);
    #2;
    in_valid = '0;
    gnt_drv  = '0;
  endtask

  task automatic put(input int c, input logic [DATA_WIDTH-1:0] d);
    in_valid[c] = 1'b1;
    in_data[c*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  initial begin
    // Reset state.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_req", 64'(req), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    check("rst_err_gnt", 64'(err_gnt), 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cycle();

    // Single client: client 2 writes 0xA5, then is granted by a directed gnt.
    put(2, 32'hA5);
    cycle();
    check("single_req", 64'(req), 64'h4);
    gnt_drv = 4'b0100;
    cycle();
    check("single_valid", 64'(out_valid), 64'h1);
    check("single_data", 64'(out_data), 64'hA5);
    check("single_id", 64'(out_id), 64'h2);
    cycle();

    // Illegal grants are ignored and latch err_gnt.
    put(0, 32'h77);
    cycle();
    check("ill_req", 64'(req), 64'h1);
    gnt_drv = 4'b0011;
    cycle();
    check("ill_multi_err", 64'(err_gnt), 64'h1);
    check("ill_multi_valid", 64'(out_valid), 64'h0);
    check("ill_multi_req", 64'(req), 64'h1);
    gnt_drv = 4'b1000;
    cycle();
    check("ill_norq_valid", 64'(out_valid), 64'h0);
    check("ill_norq_req", 64'(req), 64'h1);
    gnt_drv = 4'b0001;
    cycle();
    check("ill_then_data", 64'(out_data), 64'h77);
    check("ill_sticky", 64'(err_gnt), 64'h1);
    cycle();

    // Full and wrap-around on client 1.
    put(1, 32'h1);
    cycle();
    put(1, 32'h2);
    cycle();
    check("full_rdy", 64'(in_ready), 64'hD);
    gnt_drv = 4'b0010;
    cycle();
    check("wrap_d1", 64'(out_data), 64'h1);
    check("wrap_rdy", 64'(in_ready), 64'hF);
    put(1, 32'h3);
    cycle();
    gnt_drv = 4'b0010;
    cycle();
    check("wrap_d2", 64'(out_data), 64'h2);
    gnt_drv = 4'b0010;
    cycle();
    check("wrap_d3", 64'(out_data), 64'h3);
    cycle();

    // Round-robin with the bench arbiter: every client holds two entries.
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < REQ_WIDTH; i++) put(i, 32'h300 + 32'(i * 16 + j));
      cycle();
    end
    check("rr_full_rdy", 64'(in_ready), 64'h0);
    arb_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      cycle();
      check("rr_id", 64'(out_id), 64'(s % 4));
      check("rr_data", 64'(out_data), 64'(32'h300 + 32'((s % 4) * 16 + s / 4)));
    end
    check("rr_rdy_back", 64'(in_ready), 64'hF);
    cycle();
    arb_en = 1'b0;

    // Stall: req drops and the output holds, then service resumes after the
    // last served client.
    for (int i = 0; i < 3; i++) put(i, 32'h400 + 32'(i));
    cycle();
    arb_en = 1'b1;
    cycle();
    check("stall_first_id", 64'(out_id), 64'h0);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      check("stall_req", 64'(req), 64'h0);
      check("stall_id", 64'(out_id), 64'h0);
      check("stall_data", 64'(out_data), 64'h400);
    end
    out_ready = 1'b1;
    cycle();
    check("resume_id", 64'(out_id), 64'h1);
    cycle();
    check("resume_id2", 64'(out_id), 64'h2);
    cycle();
    arb_en = 1'b0;
    cycle();

    // Reset mid-traffic: FIFOs loaded and the output stage valid.
    out_ready = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) put(i, 32'h500 + 32'(i));
    cycle();
    gnt_drv = 4'b0001;
    cycle();
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h0);
    check("async_rst_req", 64'(req), 64'h0);
    check("async_rst_rdy", 64'(in_ready), 64'hF);
    check("async_rst_err", 64'(err_gnt), 64'h0);
    check("async_rst_data", 64'(out_data), 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cycle();
    cycle();
    check("post_rst_rdy", 64'(in_ready), 64'hF);
    check("post_rst_req", 64'(req), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
